// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe
//   Single-issue SIMD ALU with a one-entry registered result stage.
//   Ordinary ops (ADD/SUB/XOR/SLL/SRA/ROR/PADDSB/PASS) complete in one cycle.
//   RED walks the NL packed lanes serially, one lane per cycle, and then
//   delivers the signed sum of every lane of a and b.
//
// Ports
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid/in_ready   operation handshake (op, a, b sampled on accept)
//   op                  0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR,
//                       7 PADDSB, 8-F PASS
//   a, b                operands (shift amount is b[SW-1:0])
//   out_valid/out_ready result handshake
//   result              registered result
//   flag_z/v/n          registered zero / overflow / negative flags
//   busy                high while a RED iteration is running
`timescale 1ns/1ps
module simd_alu_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             busy
);

  localparam int NL = WIDTH / LANE;
  localparam int SW = $clog2(WIDTH);
  localparam int IW = (NL > 1) ? $clog2(NL) : 1;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_RED    = 4'd3;
  localparam logic [3:0] OP_SLL    = 4'd4;
  localparam logic [3:0] OP_SRA    = 4'd5;
  localparam logic [3:0] OP_ROR    = 4'd6;
  localparam logic [3:0] OP_PADDSB = 4'd7;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LMIN = {1'b1, {(LANE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    lane_idx;
  logic [WIDTH-1:0] red_a;
  logic [WIDTH-1:0] red_b;
  logic             accept;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == BUSY);

  // Single-cycle ALU. upd_z / upd_vn say which flags the op is allowed to touch.
  logic [WIDTH-1:0]           alu_res;
  logic                       alu_v;
  logic                       upd_z;
  logic                       upd_vn;
  logic [WIDTH:0]             add_ext;
  logic [WIDTH:0]             sub_ext;
  logic [SW-1:0]              sh;
  logic [LANE-1:0]            al;
  logic [LANE-1:0]            bl;
  logic [LANE:0]              lane_sum;
  logic [NL-1:0][LANE-1:0]    padd;

  always_comb begin
    sh       = b[SW-1:0];
    add_ext  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    sub_ext  = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    alu_res  = b;
    alu_v    = 1'b0;
    upd_z    = 1'b0;
    upd_vn   = 1'b0;
    al       = '0;
    bl       = '0;
    lane_sum = '0;
    padd     = '0;
    case (op)
      OP_ADD: begin
        upd_z   = 1'b1;
        upd_vn  = 1'b1;
        alu_v   = add_ext[WIDTH] ^ add_ext[WIDTH-1];
        // On overflow the true result has the sign of a, so clamp toward it.
        alu_res = alu_v ? (a[WIDTH-1] ? SMIN : SMAX) : add_ext[WIDTH-1:0];
      end
      OP_SUB: begin
        upd_z   = 1'b1;
        upd_vn  = 1'b1;
        alu_v   = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
        alu_res = alu_v ? (a[WIDTH-1] ? SMIN : SMAX) : sub_ext[WIDTH-1:0];
      end
      OP_XOR: begin
        upd_z   = 1'b1;
        alu_res = a ^ b;
      end
      OP_SLL: begin
        upd_z   = 1'b1;
        alu_res = a << sh;
      end
      OP_SRA: begin
        upd_z   = 1'b1;
        alu_res = $signed(a) >>> sh;
      end
      OP_ROR: begin
        upd_z   = 1'b1;
        // Shifting a doubled copy right brings the low bits round to the top.
        alu_res = WIDTH'({a, a} >> sh);
      end
      OP_PADDSB: begin
        for (int i = 0; i < NL; i++) begin
          al       = a[i*LANE +: LANE];
          bl       = b[i*LANE +: LANE];
          lane_sum = {al[LANE-1], al} + {bl[LANE-1], bl};
          if (lane_sum[LANE] != lane_sum[LANE-1])
            padd[i] = al[LANE-1] ? LMIN : LMAX;
          else
            padd[i] = lane_sum[LANE-1:0];
        end
        alu_res = padd;
      end
      default: alu_res = b;
    endcase
  end

  // Current RED lane of the captured operands, sign-extended and summed.
  logic [LANE-1:0]  red_al;
  logic [LANE-1:0]  red_bl;
  logic [WIDTH-1:0] red_sum;
  logic             red_last;

  always_comb begin
    red_al   = LANE'(red_a >> (LANE * lane_idx));
    red_bl   = LANE'(red_b >> (LANE * lane_idx));
    red_sum  = acc + WIDTH'($signed(red_al)) + WIDTH'($signed(red_bl));
    red_last = (lane_idx == IW'(NL - 1));
  end

  // Control FSM and result stage. A consumed result clears out_valid unless a
  // later assignment in the same edge loads a new result over it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_v    <= 1'b0;
      flag_n    <= 1'b0;
      acc       <= '0;
      lane_idx  <= '0;
      red_a     <= '0;
      red_b     <= '0;
    end else begin
      if (out_ready)
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_RED) begin
              state    <= BUSY;
              acc      <= '0;
              lane_idx <= '0;
              red_a    <= a;
              red_b    <= b;
            end else begin
              result    <= alu_res;
              out_valid <= 1'b1;
              if (upd_z)
                flag_z <= (alu_res == '0);
              if (upd_vn) begin
                flag_v <= alu_v;
                flag_n <= alu_res[WIDTH-1];
              end
            end
          end
        end
        BUSY: begin
          acc      <= red_sum;
          lane_idx <= lane_idx + IW'(1);
          if (red_last) begin
            lane_idx <= '0;
            if (!out_valid || out_ready) begin
              result    <= red_sum;
              out_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              // Never overwrite an unconsumed result; park the sum in acc.
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            result    <= acc;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/simd_alu_pipe.md
SIMD_ALU_PIPE -- requirements
Module: simd_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; SHALL be a power of two, at least 8.
REQ-002 Parameter LANE, default 4: packed-lane width for PADDSB and RED; SHALL divide WIDTH and be at least 2.
REQ-003 Derived constants SHALL be NL = WIDTH/LANE (lane count) and SW = clog2(WIDTH) (shift-amount width).
REQ-004 Clock and reset SHALL be a single clock and an asynchronous active-low reset, listed first as `clk` and `rst_n`.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  operation presented.
REQ-008 in_ready  output  1  block can accept an operation this cycle.
REQ-009 op  input  4  opcode: 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8-F PASS.
REQ-010 a  input  WIDTH  operand 1.
REQ-011 b  input  WIDTH  operand 2 (shift amount is b[SW-1:0]).
REQ-012 out_valid  output  1  result register holds an unconsumed result.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  WIDTH  registered result.
REQ-015 flag_z, flag_v, flag_n  output  1 each  registered Z/V/N flags.
REQ-016 busy  output  1  high while a RED iteration is in progress.

Function
REQ-017 Accept SHALL occur when in_valid && in_ready; a and b SHALL be sampled only on an accept.
REQ-018 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-019 The state machine SHALL have three states: IDLE, BUSY and HOLD.
REQ-020 IDLE: an accept of a non-RED op SHALL load result and flags at that edge, so out_valid is high in cycle T+1 (single-cycle latency, one op per cycle).
REQ-021 IDLE: an accept of RED SHALL go to BUSY and clear the accumulator and lane index.
REQ-022 BUSY SHALL last exactly NL cycles, adding signed lane i of a plus signed lane i of b (i = 0..NL-1, LSB lane first) into a WIDTH-bit accumulator with sign extension and no saturation.
REQ-023 On the last BUSY cycle: if !out_valid || out_ready, the sum SHALL load into result and the state SHALL return to IDLE; otherwise the state SHALL go to HOLD.
REQ-024 HOLD SHALL load the sum when out_ready is high, then return to IDLE.
REQ-025 RED latency SHALL be NL+1 cycles from accept to out_valid when there is no backpressure.
REQ-026 out_valid SHALL clear on out_ready unless a new result loads on the same edge; load and consume on the same edge SHALL leave out_valid=1 with the new data.
REQ-027 result and the flags SHALL hold stable while out_valid && !out_ready.
REQ-028 ADD/SUB SHALL compute a +/- b in signed WIDTH bits, saturating to 2^(W-1)-1 or -2^(W-1) on overflow.
REQ-029 ADD/SUB SHALL set V=overflow, N=result MSB and Z=(result==0).
REQ-030 XOR SHALL compute a^b and update Z only.
REQ-031 SLL, SRA and ROR SHALL shift or rotate a by b[SW-1:0] (SRA sign-fills) and update Z only.
REQ-032 PADDSB SHALL add each LANE-bit lane independently with signed saturation to 2^(LANE-1)-1 or -2^(LANE-1); no carry SHALL cross a lane boundary; no flag update.
REQ-033 RED SHALL leave the flags unchanged.
REQ-034 PASS (op 8-F) SHALL set result=b and leave the flags unchanged.
REQ-035 Flags SHALL update only on the edge where the corresponding result loads.
REQ-036 busy SHALL equal (state==BUSY).

Reset
REQ-037 While rst_n=0 the block SHALL immediately force state=IDLE, out_valid=0, result=0, flag_z=flag_v=flag_n=0, busy=0, accumulator=0 and lane index=0, asynchronously.
REQ-038 Reset during BUSY or HOLD SHALL abort the RED with no result produced; in_ready SHALL be 1 in the first cycle after release.

Verification (WIDTH=16, LANE=4)
REQ-039 ADD a=7FFF b=0001 -> result=7FFF, V=1, N=0, Z=0, out_valid in the cycle after accept.
REQ-040 SUB a=0005 b=0005 -> result=0000, Z=1, V=0, N=0; then ADD a=8000 b=FFFF -> result=8000, V=1, N=1.
REQ-041 PADDSB a=7878 b=1111 -> result=7979; flags unchanged from the prior op.
REQ-042 RED a=1234 b=11F1 -> busy high 4 cycles, in_ready low, result=000C at accept+5, flags unchanged.
REQ-043 Backpressure: out_ready=0 with two back-to-back ADDs -> second not accepted until the first is consumed, result stable; a RED finishing under stall enters HOLD and then delivers.
REQ-044 Reset asserted at the 2nd BUSY cycle -> all outputs 0 immediately, no out_valid after release, in_ready=1.
